// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use / branch-operand stalls, data-memory freeze,
// taken-branch flush and halt drain for the 5-stage CPU.
module hazard_stall_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ifidRs,
  input  logic [3:0]       ifidRt,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic             Halt_ID,
  input  logic [3:0]       idexWR,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [3:0]       exmemWR,
  input  logic             MemRead_MEM,
  input  logic             DataReq_MEM,
  input  logic             DataReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             PipeFreeze,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [2:0] StRun     = 3'd0;
  localparam logic [2:0] StStall   = 3'd1;
  localparam logic [2:0] StMemWait = 3'd2;
  localparam logic [2:0] StDrain   = 3'd3;
  localparam logic [2:0] StHalted  = 3'd4;

  localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainLast =
      DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [1:0]        rem_q, rem_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic src_ex, src_mem, dep_ex, dep_mem_load;
  logic load_use, br_stall, hazard, halt_req, frozen;
  logic [1:0] stall_len;

  assign src_ex  = (UsesRs_ID && (idexWR == ifidRs)) || (UsesRt_ID && (idexWR == ifidRt));
  assign src_mem = (UsesRs_ID && (exmemWR == ifidRs)) || (UsesRt_ID && (exmemWR == ifidRt));

  // R0 is hard-wired zero, so a write to it never creates a dependency.
  assign dep_ex       = RegWrite_EX && (idexWR != 4'h0) && src_ex;
  assign dep_mem_load = MemRead_MEM && (exmemWR != 4'h0) && src_mem;

  assign load_use  = MemRead_EX && dep_ex;
  assign br_stall  = Branch_ID && (dep_ex || dep_mem_load);
  assign hazard    = load_use || br_stall;
  assign stall_len = (Branch_ID && dep_ex && MemRead_EX) ? 2'd2 : 2'd1;
  assign halt_req  = Halt_ID && !BranchTaken_ID;
  assign frozen    = (state_q != StHalted) && DataReq_MEM && !DataReady;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    PipeFreeze = 1'b0;

    if (state_q == StHalted) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      PipeFreeze = 1'b1;
    end else if (frozen) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      PipeFreeze = 1'b1;
      if (state_q != StDrain) state_d = StMemWait;
    end else if (state_q == StDrain) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      if (drain_q >= DrainLast) state_d = StHalted;
      else drain_d = drain_q + DrainW'(1);
    end else if (halt_req) begin
      // The cycle HLT sits in ID counts as the first drain cycle.
      if (DRAIN_CYCLES < 2) begin
        state_d = StHalted;
      end else begin
        state_d = StDrain;
        drain_d = DrainW'(1);
      end
    end else if (hazard) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      state_d    = StStall;
      rem_d      = (state_q == StStall && rem_q != 2'd0) ? rem_q - 2'd1 : stall_len - 2'd1;
    end else begin
      state_d   = StRun;
      rem_d     = 2'd0;
      IFIDFlush = BranchTaken_ID;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!PCWrite && (state_q != StHalted) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      rem_q   <= 2'd0;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Halted      = (state_q == StHalted);
  assign StallCycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: vector table plus multi-cycle sequences.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ifidRs, ifidRt, idexWR, exmemWR;
  logic        UsesRs_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, Halt_ID;
  logic        RegWrite_EX, MemRead_EX, MemRead_MEM, DataReq_MEM, DataReady;
  logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze, Halted;
  logic [15:0] StallCycles;

  always #5 clk = ~clk;

  hazard_stall_controller #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifidRs(ifidRs), .ifidRt(ifidRt), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID), .Halt_ID(Halt_ID),
    .idexWR(idexWR), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .exmemWR(exmemWR), .MemRead_MEM(MemRead_MEM), .DataReq_MEM(DataReq_MEM),
    .DataReady(DataReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .PipeFreeze(PipeFreeze), .Halted(Halted),
    .StallCycles(StallCycles)
  );

  typedef struct packed {
    logic [3:0] rs; logic urs; logic [3:0] rt; logic urt;
    logic br; logic bt; logic hlt;
    logic [3:0] exwr; logic rwex; logic mrex;
    logic [3:0] memwr; logic mrmem; logic req; logic rdy;
  } in_t;

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze, Halted}
  typedef struct packed {
    logic pc; logic ifid; logic bub; logic fl; logic frz; logic hlt;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  localparam out_t ORun = 6'b110000;
  localparam out_t OStl = 6'b001000;
  localparam out_t OFls = 6'b110100;
  localparam out_t OFrz = 6'b000010;
  localparam out_t OHld = 6'b001011;

  out_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic in_t mk(input logic [3:0] rs, input logic urs, input logic [3:0] rt,
                             input logic urt, input logic br, input logic bt, input logic hlt,
                             input logic [3:0] exwr, input logic rwex, input logic mrex,
                             input logic [3:0] memwr, input logic mrmem, input logic req,
                             input logic rdy);
    in_t v;
    v = '{rs: rs, urs: urs, rt: rt, urt: urt, br: br, bt: bt, hlt: hlt, exwr: exwr,
          rwex: rwex, mrex: mrex, memwr: memwr, mrmem: mrmem, req: req, rdy: rdy};
    return v;
  endfunction

  task automatic drive(input in_t v);
    ifidRs = v.rs; UsesRs_ID = v.urs; ifidRt = v.rt; UsesRt_ID = v.urt;
    Branch_ID = v.br; BranchTaken_ID = v.bt; Halt_ID = v.hlt;
    idexWR = v.exwr; RegWrite_EX = v.rwex; MemRead_EX = v.mrex;
    exmemWR = v.memwr; MemRead_MEM = v.mrmem; DataReq_MEM = v.req; DataReady = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Drive on the falling edge, compare just before the next rising edge.
  task automatic step(input in_t vi, input out_t vo, input string nm);
    out_t e, act;
    @(negedge clk);
    drive(vi);
    exp_q.push_back(vo);
    #4;
    e   = exp_q.pop_front();
    act = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze, Halted};
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s outputs: got %b want %b", nm, act, e);
    end
    if (StallCycles !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s StallCycles: got %0d want %0d", nm, StallCycles, exp_cnt);
    end
    if (!e.pc && !e.hlt && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    exp_q.delete();
  endtask

  vec_t tbl[18];
  in_t  idle, lu, lu_wait, lu_rdy, ld_mem, halt;

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu      = mk(3, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    lu_wait = mk(3, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0);
    lu_rdy  = mk(3, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1);
    ld_mem  = mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    halt    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    //              rs urs rt urt br bt hlt exwr rw mr memwr mrm req rdy
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ORun};
    tbl[1]  = '{lu, OStl};
    tbl[2]  = '{ld_mem, ORun};
    tbl[3]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), ORun};
    tbl[4]  = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), ORun};
    tbl[5]  = '{mk(0, 0, 7, 1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0), ORun};
    tbl[6]  = '{mk(5, 1, 0, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0), OStl};
    tbl[7]  = '{mk(5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0), OStl};
    tbl[8]  = '{mk(5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), OFls};
    tbl[9]  = '{mk(0, 0, 6, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0), OStl};
    tbl[10] = '{mk(0, 0, 6, 1, 1, 1, 0, 0, 0, 0, 6, 0, 0, 0), OFls};
    tbl[11] = '{mk(0, 0, 6, 0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0), ORun};
    tbl[12] = '{mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), ORun};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), OFls};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ORun};
    tbl[15] = '{mk(3, 1, 0, 0, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0), OStl};
    tbl[16] = '{mk(9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0), OStl};
    tbl[17] = '{idle, ORun};

    rst_n = 1'b0;
    drive(idle);
    #3;
    chk("reset_halted", {15'd0, Halted}, 16'd0);
    chk("reset_cnt", StallCycles, 16'd0);
    chk("reset_pcwrite", {15'd0, PCWrite}, 16'd1);
    do_reset();

    for (int k = 0; k < 18; k++) step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    // Data-memory wait overlapping a load-use hazard.
    do_reset();
    for (int k = 0; k < 4; k++) step(lu_wait, OFrz, $sformatf("memwait%0d", k));
    step(lu_rdy, OStl, "memwait_release");
    step(ld_mem, ORun, "memwait_resume");
    chk("memwait_cnt", StallCycles, 16'd5);

    // Halt drain: Halted exactly three cycles after HLT in ID, then sticky.
    do_reset();
    step(halt, ORun, "halt_id");
    step(idle, OStl, "drain1");
    step(idle, OStl, "drain2");
    step(idle, OHld, "halted0");
    step(lu_wait, OHld, "halted_ignores_inputs");
    step(halt, OHld, "halted_sticky");
    chk("halt_cnt", StallCycles, 16'd2);

    // A freeze during drain must not advance the drain count.
    do_reset();
    step(halt, ORun, "fz_halt_id");
    step(idle, OStl, "fz_drain1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), OFrz, "fz_frozen");
    step(idle, OStl, "fz_drain2");
    step(idle, OHld, "fz_halted");

    // Asynchronous reset mid-drain.
    do_reset();
    step(halt, ORun, "rst_halt_id");
    step(idle, OStl, "rst_drain1");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_halted", {15'd0, Halted}, 16'd0);
    chk("rst_mid_cnt", StallCycles, 16'd0);
    chk("rst_mid_pcwrite", {15'd0, PCWrite}, 16'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    step(idle, ORun, "rst_resume");

    // Counter saturation.
    do_reset();
    drive(lu);
    repeat (65540) @(negedge clk);
    chk("sat_cnt", StallCycles, 16'hFFFF);
    chk("sat_pcwrite", {15'd0, PCWrite}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage CPU. It sits beside the EX-stage forwarding logic and handles the hazards that forwarding cannot resolve: load-use, branch-operand dependencies resolved in ID, multi-cycle data-memory waits, taken-branch flush, and halt drain. It drives the PC/plr write-enables, bubble and flush controls, and exposes a halted flag and a stall-cycle counter.

Parameters:
DRAIN_CYCLES, 3, cycles after a halt reaches ID before Halted asserts (EX, MEM, WB drain)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ifidRs  input  4  source register 1 of the instruction in ID
ifidRt  input  4  source register 2 of the instruction in ID
UsesRs_ID  input  1  ID instruction reads ifidRs
UsesRt_ID  input  1  ID instruction reads ifidRt
Branch_ID  input  1  ID instruction is a register-dependent branch
BranchTaken_ID  input  1  branch in ID resolved taken this cycle
Halt_ID  input  1  ID instruction is HLT
idexWR  input  4  destination register in ID/EX
RegWrite_EX  input  1  ID/EX instruction writes a register
MemRead_EX  input  1  ID/EX instruction is a load
exmemWR  input  4  destination register in EX/MEM
MemRead_MEM  input  1  EX/MEM instruction is a load
DataReq_MEM  input  1  data-memory access active in MEM
DataReady  input  1  data memory completes access this cycle
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID plr write enable
IDEXBubble  output  1  insert NOP into ID/EX
IFIDFlush  output  1  zero IF/ID on next edge
PipeFreeze  output  1  hold ID/EX, EX/MEM, MEM/WB plrs
Halted  output  1  sticky: pipeline drained after HLT
StallCycles  output  CNT_W  saturating count of cycles with PCWrite=0 while not halted

Behaviour:
- States: RUN, STALL, MEMWAIT, DRAIN, HALTED. Reset (async, rst_n=0): state RUN, StallCycles=0, Halted=0, drain counter 0. All outputs are combinational from state and inputs; in RUN with no hazard: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, PipeFreeze=0.
- Register 0 is never a dependency: a destination of 4'h0 matches nothing.
- depEX = RegWrite_EX && idexWR!=0 && ((UsesRs_ID && idexWR==ifidRs) || (UsesRt_ID && idexWR==ifidRt)); depMEMload = MemRead_MEM && exmemWR!=0 with the same source match.
- Priority per cycle, highest first: MEMWAIT condition, halt, load-use/branch stall, taken-branch flush.
- MEMWAIT: DataReq_MEM && !DataReady (any state except HALTED) -> PipeFreeze=1, PCWrite=0, IFIDWrite=0, IDEXBubble=0; stay until DataReady=1; in the DataReady cycle PipeFreeze=0 and normal evaluation applies. STALL and DRAIN counters do not advance while frozen.
- Load-use: MemRead_EX && depEX -> 1 stall cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- Branch dependency (Branch_ID): depEX with MemRead_EX -> 2 stall cycles; depEX without load -> 1 stall cycle; depMEMload -> 1 stall cycle. STALL holds a 2-bit remaining count loaded on entry; the hazard is re-evaluated each cycle so a 2-cycle stall ends early only via re-evaluation, never extends beyond the detected dependency.
- BranchTaken_ID honoured only when not stalling/frozen: IFIDFlush=1 for exactly that cycle, PCWrite=1.
- Halt_ID (not stalling/frozen): PCWrite=0, IFIDWrite=0, IDEXBubble=1 from the next cycle; enter DRAIN, count DRAIN_CYCLES unfrozen cycles, then HALTED: Halted=1, PCWrite=0, IFIDWrite=0, IDEXBubble=1, PipeFreeze=1 until reset. Halt in ID is squashed (ignored) if BranchTaken_ID is set the same cycle.
- StallCycles: +1 each cycle PCWrite=0 and state != HALTED; saturates at all-ones.
- Reset asserted mid-stall/drain: immediate return to RUN, counters cleared.

Test Plan:
- LDR R3 in EX, ID reads R3 via Rs -> exactly one cycle PCWrite=0, IDEXBubble=1, then RUN; StallCycles=1.
- Load to R5 in EX, ID branch on R5 -> two stall cycles, then BranchTaken_ID=1 gives IFIDFlush=1 for one cycle.
- ADD writing R0 in EX, ID reads R0 -> no stall, PCWrite stays 1.
- DataReq_MEM=1, DataReady low 4 cycles, concurrent load-use -> PipeFreeze=1 for 4 cycles, load-use stall occurs after release; StallCycles=5.
- Halt_ID pulse -> Halted=1 exactly DRAIN_CYCLES=3 cycles later, PCWrite=0 thereafter; rst_n low mid-DRAIN clears Halted and StallCycles.
- Force 65540 stall cycles -> StallCycles holds 16'hFFFF.
